dice_score_multi: RTL and testbench
===================================

// Module: dice_score_multi
// PURPOSE
//  N-player, R-round score keeper for the dice game; parametrised successor of the 2-player scorer.
//  Each round, every player presses start. Once all have pressed, dice are sampled and the round winner is scored.
//  A result-display window follows, then the next round begins. After ROUNDS rounds it declares the final winner or a draw.
//  Sits between the per-player dice generators and the score/segment display driver.
// PARAMETERS
//  N_PLAYERS   2         number of players (>=2)
//  DICE_W      4         width of each dice value
//  SCORE_W     4         width of each score; saturates at 2^SCORE_W-1
//  ROUNDS      5         rounds per game (>=1)
//  SHOW_CYCLES 30000000  clk cycles the round result is held (>=1)
//  SCORE_MODE  0         0: round winner +1; 1: round winner +(max - second highest dice)
// PORTS
//  clk          in   1                  system clock, rising edge
//  rst          in   1                  asynchronous, active-high reset
//  start        in   N_PLAYERS          raw push buttons, one per player (asynchronous)
//  dice         in   N_PLAYERS*DICE_W   player i dice at [i*DICE_W +: DICE_W]
//  restart      in   1                  synchronous; begins a new game from DONE
//  score        out  N_PLAYERS*SCORE_W  player i score at [i*SCORE_W +: SCORE_W]
//  round_cnt    out  $clog2(ROUNDS+1)   completed rounds
//  pressed      out  N_PLAYERS          players who have pressed in the current round
//  showing      out  1                  high during the result window
//  last_winner  out  $clog2(N_PLAYERS)  index of the last round winner (valid while showing)
//  last_tie     out  1                  last round tied at the top (valid while showing)
//  is_final     out  1                  current round is the last one (round_cnt==ROUNDS-1, not DONE)
//  finish       out  1                  game over
//  winner       out  $clog2(N_PLAYERS)  overall winner index (valid when winner_valid)
//  winner_valid out  1                  finish && unique top score
//  draw         out  1                  finish && tied top score
// BEHAVIOUR
//  Reset: state=ARM; all outputs and internal registers are 0.
//  Input conditioning: each start[i] passes through a 2-FF synchroniser, then rising-edge detection.
//    An edge sets pressed[i] no earlier than 3 clks after the raw rise.
//  Held buttons do not re-trigger. Edges outside ARM are ignored and do not set pressed.
//  FSM:
//   ARM:  accumulate pressed. When &pressed=1, capture dice into dice_q on that edge and go to EVAL.
//   EVAL (1 clk): compute max and second-highest over dice_q. tie = (more than one player holds max).
//     Not tie: score[w] += (SCORE_MODE ? max-second : 1), saturating; last_winner=w; last_tie=0.
//     Tie: no score change; last_tie=1; last_winner unchanged.
//     On exit: clear pressed, load timer=SHOW_CYCLES-1, go to SHOW.
//   SHOW: showing=1; timer decrements each clk. At timer==0: round_cnt+=1.
//     If the new round_cnt==ROUNDS, go to DONE; else go to ARM.
//   DONE: finish=1; winner, winner_valid and draw are registered on entry and held.
//     restart=1 clears scores, round_cnt and all flags, then goes to ARM next clk.
//     restart is ignored in every other state.
//  Dice value 0 is scored like any other value; SCORE_MODE=1 with equal top values is a tie.
//  Dice changes after capture have no effect on the current round.
//  Final winner is the lowest-index player among those holding the unique maximum score.
//    Any tie at the top gives draw=1 and winner=0.
//  rst asserted in any state aborts at once: all state and outputs return to reset values.
//  Timer width is $clog2(SHOW_CYCLES+1). No combinational path from inputs to outputs.
// TESTING (bench uses SHOW_CYCLES=8, N_PLAYERS=3, ROUNDS=3)
//  1. rst pulse; press 0,1,2 with dice 5,3,2; SCORE_MODE=0 -> score0=1, last_winner=0, showing for 8 clks, round_cnt=1.
//  2. Same dice with SCORE_MODE=1 -> score0=2 (5-3).
//     Dice 15,0,0 with SCORE_W=4 repeated -> score saturates at 15.
//  3. Dice 4,4,1 -> last_tie=1, all scores unchanged, round_cnt still increments.
//  4. Hold start0 high across 2 rounds; press during SHOW -> ignored, pressed stays 0 until a fresh rise in ARM.
//  5. Full game with player 2 winning 2 of 3 rounds -> is_final high in round 3.
//     finish=1, winner=2, winner_valid=1. restart -> scores=0, state ARM.
//  6. rst mid-SHOW -> outputs 0 next edge-independent; a tied final game gives draw=1 and winner_valid=0.

Source files
------------

// File: rtl/dice_score_multi.sv
`default_nettype none
// ============================================================================
// Module      : dice_score_multi
// Description : N-player, R-round dice game score keeper. Collects one start
//               press per player, scores the round winner, holds the result,
//               and declares the overall winner or a draw.
// Revision    : 1.0 - initial release
// ============================================================================
module dice_score_multi #(
    parameter int N_PLAYERS   = 2,
    parameter int DICE_W      = 4,
    parameter int SCORE_W     = 4,
    parameter int ROUNDS      = 5,
    parameter int SHOW_CYCLES = 30000000,
    parameter int SCORE_MODE  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_PLAYERS-1:0]             start,
    input  logic [N_PLAYERS*DICE_W-1:0]      dice,
    input  logic                             restart,
    output logic [N_PLAYERS*SCORE_W-1:0]     score,
    output logic [$clog2(ROUNDS+1)-1:0]      round_cnt,
    output logic [N_PLAYERS-1:0]             pressed,
    output logic                             showing,
    output logic [$clog2(N_PLAYERS)-1:0]     last_winner,
    output logic                             last_tie,
    output logic                             is_final,
    output logic                             finish,
    output logic [$clog2(N_PLAYERS)-1:0]     winner,
    output logic                             winner_valid,
    output logic                             draw
);
    localparam int c_PI_W  = $clog2(N_PLAYERS);
    localparam int c_RC_W  = $clog2(ROUNDS + 1);
    localparam int c_TMR_W = $clog2(SHOW_CYCLES + 1);
    localparam int c_SUM_W = ((SCORE_W > DICE_W) ? SCORE_W : DICE_W) + 1;

    localparam logic [1:0] c_ARM  = 2'd0;
    localparam logic [1:0] c_EVAL = 2'd1;
    localparam logic [1:0] c_SHOW = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]                   r_state, w_state_next;
    logic [N_PLAYERS-1:0]         r_sync1, r_sync2, r_sync3, w_rise;
    logic [N_PLAYERS-1:0]         r_pressed;
    logic [N_PLAYERS*DICE_W-1:0]  r_dice_q;
    logic [N_PLAYERS*SCORE_W-1:0] r_score, w_score_upd;
    logic [c_RC_W-1:0]            r_round_cnt;
    logic [c_TMR_W-1:0]           r_timer;
    logic [c_PI_W-1:0]            r_last_winner, r_winner;
    logic                         r_last_tie, r_winner_valid, r_draw;

    logic [DICE_W-1:0]            w_dice_max, w_dice_second, w_inc;
    logic [c_PI_W-1:0]            w_dice_idx, w_final_idx;
    logic                         w_dice_tie, w_final_tie;
    logic [c_SUM_W-1:0]           w_sum;
    logic [SCORE_W-1:0]           w_score_max;
    logic                         w_show_end, w_last_round;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= start;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise       = r_sync2 & ~r_sync3;
    assign w_show_end   = (r_timer == '0);
    assign w_last_round = ((r_round_cnt + c_RC_W'(1)) == c_RC_W'(ROUNDS));

    // Round evaluation: lowest-index maximum, runner-up over the others, tie flag
    always_comb begin
        w_dice_max    = '0;
        w_dice_idx    = '0;
        w_dice_second = '0;
        w_dice_tie    = 1'b0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (r_dice_q[i*DICE_W +: DICE_W] > w_dice_max) begin
                w_dice_max = r_dice_q[i*DICE_W +: DICE_W];
                w_dice_idx = c_PI_W'(i);
            end
        end
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (c_PI_W'(i) != w_dice_idx) begin
                if (r_dice_q[i*DICE_W +: DICE_W] == w_dice_max) w_dice_tie = 1'b1;
                if (r_dice_q[i*DICE_W +: DICE_W] > w_dice_second)
                    w_dice_second = r_dice_q[i*DICE_W +: DICE_W];
            end
        end
        w_inc = (SCORE_MODE != 0) ? (w_dice_max - w_dice_second) : DICE_W'(1);
    end

    always_comb begin
        w_score_upd = r_score;
        w_sum       = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (c_PI_W'(i) == w_dice_idx) begin
                w_sum = c_SUM_W'(r_score[i*SCORE_W +: SCORE_W]) + c_SUM_W'(w_inc);
                w_score_upd[i*SCORE_W +: SCORE_W] =
                    (|w_sum[c_SUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
            end
        end
    end

    always_comb begin
        w_score_max = '0;
        w_final_idx = '0;
        w_final_tie = 1'b0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (r_score[i*SCORE_W +: SCORE_W] > w_score_max) begin
                w_score_max = r_score[i*SCORE_W +: SCORE_W];
                w_final_idx = c_PI_W'(i);
            end
        end
        for (int i = 0; i < N_PLAYERS; i++) begin
            if ((c_PI_W'(i) != w_final_idx) && (r_score[i*SCORE_W +: SCORE_W] == w_score_max))
                w_final_tie = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ARM;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ARM:  if (&r_pressed) w_state_next = c_EVAL;
            c_EVAL: w_state_next = c_SHOW;
            c_SHOW: if (w_show_end) w_state_next = w_last_round ? c_DONE : c_ARM;
            c_DONE: if (restart) w_state_next = c_ARM;
            default: w_state_next = c_ARM;
        endcase
    end

    always_comb begin
        showing  = (r_state == c_SHOW);
        finish   = (r_state == c_DONE);
        is_final = (r_state != c_DONE) && (r_round_cnt == c_RC_W'(ROUNDS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pressed      <= '0;
            r_dice_q       <= '0;
            r_score        <= '0;
            r_round_cnt    <= '0;
            r_timer        <= '0;
            r_last_winner  <= '0;
            r_last_tie     <= 1'b0;
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
            r_draw         <= 1'b0;
        end else begin
            case (r_state)
                c_ARM: begin
                    r_pressed <= r_pressed | w_rise;
                    if (&r_pressed) r_dice_q <= dice;
                end
                c_EVAL: begin
                    if (w_dice_tie) begin
                        r_last_tie <= 1'b1;
                    end else begin
                        r_score       <= w_score_upd;
                        r_last_winner <= w_dice_idx;
                        r_last_tie    <= 1'b0;
                    end
                    r_pressed <= '0;
                    r_timer   <= c_TMR_W'(SHOW_CYCLES - 1);
                end
                c_SHOW: begin
                    if (w_show_end) begin
                        r_round_cnt <= r_round_cnt + c_RC_W'(1);
                        if (w_last_round) begin
                            r_winner       <= w_final_tie ? '0 : w_final_idx;
                            r_winner_valid <= ~w_final_tie;
                            r_draw         <= w_final_tie;
                        end
                    end else begin
                        r_timer <= r_timer - c_TMR_W'(1);
                    end
                end
                c_DONE: begin
                    if (restart) begin
                        r_score        <= '0;
                        r_round_cnt    <= '0;
                        r_last_winner  <= '0;
                        r_last_tie     <= 1'b0;
                        r_winner       <= '0;
                        r_winner_valid <= 1'b0;
                        r_draw         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign score        = r_score;
    assign round_cnt    = r_round_cnt;
    assign pressed      = r_pressed;
    assign last_winner  = r_last_winner;
    assign last_tie     = r_last_tie;
    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;
    assign draw         = r_draw;

endmodule
`default_nettype wire

// File: tb/tb_dice_score_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_dice_score_multi
// Description : Directed bench for dice_score_multi, 3 players, 3 rounds,
//               8-cycle result window, both scoring modes side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dice_score_multi;
    localparam int NP = 3;
    localparam int DW = 4;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst, restart;
    logic [NP-1:0]    start;
    logic [NP*DW-1:0] dice;

    logic [NP*SW-1:0] score0, score1;
    logic [1:0]       rcnt0, rcnt1, lw0, lw1, win0, win1;
    logic [2:0]       pressed0, pressed1;
    logic             showing0, showing1, lt0, lt1, isf0, isf1, fin0, fin1;
    logic             wv0, wv1, dr0, dr1;
    logic [26:0]      all0, all1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dice_score_multi #(.N_PLAYERS(NP), .DICE_W(DW), .SCORE_W(SW), .ROUNDS(3),
                       .SHOW_CYCLES(8), .SCORE_MODE(0)) dut_m0 (
        .clk(clk), .rst(rst), .start(start), .dice(dice), .restart(restart),
        .score(score0), .round_cnt(rcnt0), .pressed(pressed0), .showing(showing0),
        .last_winner(lw0), .last_tie(lt0), .is_final(isf0), .finish(fin0),
        .winner(win0), .winner_valid(wv0), .draw(dr0)
    );

    dice_score_multi #(.N_PLAYERS(NP), .DICE_W(DW), .SCORE_W(SW), .ROUNDS(3),
                       .SHOW_CYCLES(8), .SCORE_MODE(1)) dut_m1 (
        .clk(clk), .rst(rst), .start(start), .dice(dice), .restart(restart),
        .score(score1), .round_cnt(rcnt1), .pressed(pressed1), .showing(showing1),
        .last_winner(lw1), .last_tie(lt1), .is_final(isf1), .finish(fin1),
        .winner(win1), .winner_valid(wv1), .draw(dr1)
    );

    assign all0 = {score0, rcnt0, pressed0, showing0, lw0, lt0, isf0, fin0, win0, wv0, dr0};
    assign all1 = {score1, rcnt1, pressed1, showing1, lw1, lt1, isf1, fin1, win1, wv1, dr1};

    // Plays one round; dice are scrambled right after capture to prove they are latched
    task automatic play_round(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                              output int delay, output int shows,
                              output logic [1:0] lw, output logic lt, output bit ok);
        int guard;
        ok = 1'b1; delay = 0; shows = 0; lw = '0; lt = 1'b0;
        dice  = {d2, d1, d0};
        start = 3'b111;
        while (pressed0 != 3'b111 && delay < 20) begin @(negedge clk); delay++; end
        if (pressed0 != 3'b111) ok = 1'b0;
        @(negedge clk);
        dice  = 12'hFF0;
        guard = 0;
        while (!showing0 && guard < 20) begin @(negedge clk); guard++; end
        if (!showing0) ok = 1'b0;
        lw = lw0; lt = lt0;
        start = 3'b000;
        while (showing0 && shows < 100) begin @(negedge clk); shows++; end
        if (showing0) ok = 1'b0;
    endtask

    task automatic pulse_restart;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = '0; dice = '0; restart = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (all0 !== 27'd0) begin errors++; $display("FAIL reset_m0: got %h expected 0", all0); end
        checks++; if (all1 !== 27'd0) begin errors++; $display("FAIL reset_m1: got %h expected 0", all1); end
        repeat (4) @(negedge clk);
        checks++; if ({pressed0, showing0, rcnt0} !== 6'd0) begin
            errors++; $display("FAIL idle_arm: got %h expected 0", {pressed0, showing0, rcnt0}); end
    endtask

    task automatic test_round_basic;
        int delay, shows; logic [1:0] lw; logic lt; bit ok;
        play_round(4'd5, 4'd3, 4'd2, delay, shows, lw, lt, ok);
        checks++; if (!ok) begin errors++; $display("FAIL r1_timeout: got %0d expected 1", ok); end
        checks++; if (delay < 3 || delay > 4) begin errors++; $display("FAIL press_latency: got %0d expected 3..4", delay); end
        checks++; if (shows !== 8) begin errors++; $display("FAIL show_len: got %0d expected 8", shows); end
        checks++; if (lw !== 2'd0 || lt !== 1'b0) begin errors++; $display("FAIL r1_last: got %0d/%0d expected 0/0", lw, lt); end
        checks++; if (score0 !== 12'h001) begin errors++; $display("FAIL r1_score_m0: got %h expected 001", score0); end
        checks++; if (score1 !== 12'h002) begin errors++; $display("FAIL r1_score_m1: got %h expected 002", score1); end
        checks++; if ({rcnt0, isf0, pressed0} !== {2'd1, 1'b0, 3'b000}) begin
            errors++; $display("FAIL r1_status: got %h expected %h", {rcnt0, isf0, pressed0}, {2'd1, 1'b0, 3'b000}); end
    endtask

    task automatic test_tie;
        int delay, shows; logic [1:0] lw; logic lt; bit ok;
        play_round(4'd4, 4'd4, 4'd1, delay, shows, lw, lt, ok);
        checks++; if (!ok || shows !== 8) begin errors++; $display("FAIL r2_flow: got ok=%0d shows=%0d expected 1/8", ok, shows); end
        checks++; if (lt !== 1'b1 || lw !== 2'd0) begin errors++; $display("FAIL tie_flag: got %0d/%0d expected 1/0", lt, lw); end
        checks++; if ({score0, score1} !== {12'h001, 12'h002}) begin
            errors++; $display("FAIL tie_scores: got %h expected 001002", {score0, score1}); end
        checks++; if (rcnt0 !== 2'd2 || isf0 !== 1'b1) begin errors++; $display("FAIL tie_round: got %0d/%0d expected 2/1", rcnt0, isf0); end
    endtask

    task automatic test_saturate_finish;
        int delay, shows; logic [1:0] lw; logic lt; bit ok;
        play_round(4'd15, 4'd0, 4'd0, delay, shows, lw, lt, ok);
        checks++; if (!ok || lt !== 1'b0 || lw !== 2'd0) begin
            errors++; $display("FAIL r3_flow: got ok=%0d lt=%0d lw=%0d expected 1/0/0", ok, lt, lw); end
        checks++; if (score0 !== 12'h002) begin errors++; $display("FAIL r3_score_m0: got %h expected 002", score0); end
        checks++; if (score1 !== 12'h00F) begin errors++; $display("FAIL saturate_m1: got %h expected 00f", score1); end
        checks++; if ({fin0, win0, wv0, dr0, isf0, rcnt0} !== {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd3}) begin
            errors++; $display("FAIL gameA_done_m0: got %h expected %h", {fin0, win0, wv0, dr0, isf0, rcnt0}, {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd3}); end
        checks++; if ({fin1, win1, wv1, dr1} !== {1'b1, 2'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL gameA_done_m1: got %h expected %h", {fin1, win1, wv1, dr1}, {1'b1, 2'd0, 1'b1, 1'b0}); end
        start = 3'b111;
        repeat (5) @(negedge clk);
        checks++; if (pressed0 !== 3'b000 || fin0 !== 1'b1) begin
            errors++; $display("FAIL press_in_done: got %b/%0d expected 000/1", pressed0, fin0); end
        start = 3'b000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_restart;
        pulse_restart();
        checks++; if ({score0, rcnt0, fin0, wv0, dr0, lt0, lw0} !== 21'd0) begin
            errors++; $display("FAIL restart_m0: got %h expected 0", {score0, rcnt0, fin0, wv0, dr0, lt0, lw0}); end
        checks++; if ({score1, fin1} !== 13'd0) begin errors++; $display("FAIL restart_m1: got %h expected 0", {score1, fin1}); end
    endtask

    task automatic test_held_start;
        int guard, bad; logic [1:0] lwc;
        bad = 0; lwc = '0;
        dice  = {4'd9, 4'd2, 4'd1};
        start = 3'b111;
        guard = 0;
        while (pressed0 != 3'b111 && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);
        dice  = 12'hFF0;
        guard = 0;
        while (!showing0 && guard < 20) begin @(negedge clk); guard++; end
        checks++; if (!showing0) begin errors++; $display("FAIL held_r1_show: got %0d expected 1", showing0); end
        lwc   = lw0;
        start = 3'b001;
        repeat (2) begin @(negedge clk); if (pressed0 != 3'b000) bad++; end
        start = 3'b101;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        guard = 0;
        while (showing0 && guard < 100) begin if (pressed0 != 3'b000) bad++; @(negedge clk); guard++; end
        checks++; if (showing0) begin errors++; $display("FAIL held_r1_end: got %0d expected 0", showing0); end
        repeat (5) begin @(negedge clk); if ((pressed0 | pressed1) != 3'b000) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL held_no_retrigger: got %0d bad cycles expected 0", bad); end
        checks++; if ({score0, score1} !== {12'h100, 12'h700}) begin
            errors++; $display("FAIL held_scores: got %h expected 100700", {score0, score1}); end
        checks++; if (rcnt0 !== 2'd1 || lwc !== 2'd2) begin
            errors++; $display("FAIL held_round: got %0d/%0d expected 1/2", rcnt0, lwc); end
        start = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_game;
        int delay, shows; logic [1:0] lw; logic lt; bit ok;
        play_round(4'd7, 4'd3, 4'd6, delay, shows, lw, lt, ok);
        checks++; if (!ok || lw !== 2'd0) begin errors++; $display("FAIL b_r2_flow: got ok=%0d lw=%0d expected 1/0", ok, lw); end
        checks++; if ({score0, score1} !== {12'h101, 12'h701}) begin
            errors++; $display("FAIL b_r2_scores: got %h expected 101701", {score0, score1}); end
        checks++; if (isf0 !== 1'b1 || rcnt0 !== 2'd2) begin errors++; $display("FAIL b_is_final: got %0d/%0d expected 1/2", isf0, rcnt0); end
        play_round(4'd0, 4'd1, 4'd3, delay, shows, lw, lt, ok);
        checks++; if (!ok || lw !== 2'd2) begin errors++; $display("FAIL b_r3_flow: got ok=%0d lw=%0d expected 1/2", ok, lw); end
        checks++; if ({score0, score1} !== {12'h201, 12'h901}) begin
            errors++; $display("FAIL b_r3_scores: got %h expected 201901", {score0, score1}); end
        checks++; if ({fin0, win0, wv0, dr0} !== {1'b1, 2'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL b_winner_m0: got %h expected %h", {fin0, win0, wv0, dr0}, {1'b1, 2'd2, 1'b1, 1'b0}); end
        checks++; if ({fin1, win1, wv1, dr1} !== {1'b1, 2'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL b_winner_m1: got %h expected %h", {fin1, win1, wv1, dr1}, {1'b1, 2'd2, 1'b1, 1'b0}); end
        pulse_restart();
        checks++; if ({score0, rcnt0, fin0, wv0} !== 16'd0) begin
            errors++; $display("FAIL b_restart: got %h expected 0", {score0, rcnt0, fin0, wv0}); end
    endtask

    task automatic test_rst_mid_show;
        int guard;
        dice  = {4'd2, 4'd3, 4'd5};
        start = 3'b011;
        repeat (5) @(negedge clk);
        checks++; if (pressed0 !== 3'b011 || showing0 !== 1'b0) begin
            errors++; $display("FAIL partial_press: got %b/%0d expected 011/0", pressed0, showing0); end
        start = 3'b111;
        guard = 0;
        while (!showing0 && guard < 20) begin @(negedge clk); guard++; end
        checks++; if (!showing0 || score0 !== 12'h001) begin
            errors++; $display("FAIL c_show: got %0d/%h expected 1/001", showing0, score0); end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (all0 !== 27'd0) begin errors++; $display("FAIL async_rst_m0: got %h expected 0", all0); end
        checks++; if (all1 !== 27'd0) begin errors++; $display("FAIL async_rst_m1: got %h expected 0", all1); end
        start = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_draw_final;
        int delay, shows; logic [1:0] lw; logic lt; bit ok, ok_all;
        ok_all = 1'b1;
        play_round(4'd5, 4'd1, 4'd1, delay, shows, lw, lt, ok); ok_all &= ok;
        play_round(4'd1, 4'd5, 4'd1, delay, shows, lw, lt, ok); ok_all &= ok;
        play_round(4'd4, 4'd4, 4'd4, delay, shows, lw, lt, ok); ok_all &= ok;
        checks++; if (!ok_all || lt !== 1'b1) begin errors++; $display("FAIL d_flow: got ok=%0d lt=%0d expected 1/1", ok_all, lt); end
        checks++; if ({score0, score1} !== {12'h011, 12'h044}) begin
            errors++; $display("FAIL d_scores: got %h expected 011044", {score0, score1}); end
        checks++; if ({fin0, win0, wv0, dr0} !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL draw_m0: got %h expected %h", {fin0, win0, wv0, dr0}, {1'b1, 2'd0, 1'b0, 1'b1}); end
        checks++; if ({fin1, win1, wv1, dr1} !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL draw_m1: got %h expected %h", {fin1, win1, wv1, dr1}, {1'b1, 2'd0, 1'b0, 1'b1}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = '0; dice = '0; restart = 1'b0;
        test_reset();
        test_round_basic();
        test_tie();
        test_saturate_finish();
        test_restart();
        test_held_start();
        test_full_game();
        test_rst_mid_show();
        test_draw_final();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
